// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: base opcodes, request format codes, error word.
// Latency: none (constants only).
// Backpressure: not applicable.
package rv_isa_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] ArithmeticR   = 7'b0110011;
  localparam logic [6:0] ArithmeticI   = 7'b0010011;
  localparam logic [6:0] Conditionjump = 7'b1100011;
  localparam logic [6:0] MemoryLoad    = 7'b0000011;
  localparam logic [6:0] MemoryStore   = 7'b0100011;
  localparam logic [6:0] JumpandlinkR  = 7'b1100111;
  localparam logic [6:0] JumpandlinkI  = 7'b1101111;
  localparam logic [6:0] Adduppertopc  = 7'b0010111;
  localparam logic [6:0] Loadupperimm  = 7'b0110111;

  // Request format codes carried on in_fmt
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_LI  = 3'd6;
  localparam logic [2:0] FMT_RSV = 3'd7;

  // addi x0,x0,0 -- harmless word emitted for a rejected request
  localparam logic [31:0] NOP_WORD = 32'h00000013;

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational field packer for one RV32I word with immediate range checks.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers and flow-controls the result.
// Ports: fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in; word (NOP_WORD on error), err out.
module inst_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  // A value sign-fits N bits when every bit above N-1 copies bit N-1.
  function automatic logic fits_s12(input logic [31:0] v);
    return v[31:11] == {21{v[11]}};
  endfunction

  function automatic logic fits_s13(input logic [31:0] v);
    return v[31:12] == {20{v[12]}};
  endfunction

  function automatic logic fits_s21(input logic [31:0] v);
    return v[31:20] == {12{v[20]}};
  endfunction

  logic is_shift;
  assign is_shift = (opcode == ArithmeticI) && (funct3[1:0] == 2'b01);

  always_comb begin
    word = NOP_WORD;
    err  = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          // shamt is unsigned 5 bits; funct7 supplies the slli/srli/srai selector
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          err  = (imm[31:5] != 27'd0);
        end else begin
          word = {imm[11:0], rs1, funct3, rd, opcode};
          err  = !fits_s12(imm);
        end
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !fits_s12(imm);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !fits_s13(imm) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !fits_s21(imm) || imm[0];
      end
      // LI is expanded by the caller into I/U requests; reaching here is an error.
      default: err = 1'b1;
    endcase
    if (err) word = NOP_WORD;
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: builds RV32I words from fields, expanding li into LUI+ADDI when needed.
// Latency: 1 cycle accept-to-output; 1 req/cycle for single-beat requests.
// Backpressure: output held while out_valid&&!out_ready; in_ready low then and during a pending 2nd beat.
// Ports: clk, rstn; in_* request (valid/ready); out_* beat (valid/ready) with out_last, out_err.
module inst_encoder
  import rv_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [31:0] pend_inst_q, pend_inst_d;
  logic        pend_err_q, pend_err_d;

  // li classification
  logic        is_li, li_small, li_lo_zero, li_two;
  logic [19:0] li_hi;
  assign is_li      = (in_fmt == FMT_LI);
  assign li_small   = (in_imm[31:11] == {21{in_imm[11]}});
  assign li_lo_zero = (in_imm[11:0] == 12'd0);
  assign li_two     = is_li && !li_small && !li_lo_zero;
  // ADDI sign-extends its low 12 bits, so round the upper part up when bit 11 is set.
  assign li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};

  // Primary word: the request itself, or the first li instruction (ADDI x0 / LUI).
  logic [2:0]  p0_fmt;
  logic [6:0]  p0_opcode;
  logic [4:0]  p0_rs1;
  logic [2:0]  p0_funct3;
  logic [31:0] p0_imm, p0_word, p1_word;
  logic        p0_err, p1_err;

  assign p0_fmt    = !is_li ? in_fmt    : (li_small ? FMT_I : FMT_U);
  assign p0_opcode = !is_li ? in_opcode : (li_small ? ArithmeticI : Loadupperimm);
  assign p0_rs1    = is_li ? 5'd0 : in_rs1;
  assign p0_funct3 = is_li ? 3'd0 : in_funct3;
  assign p0_imm    = (is_li && !li_small) ? {li_hi, 12'd0} : in_imm;

  inst_pack u_pack_main (
    .fmt    (p0_fmt),
    .opcode (p0_opcode),
    .rd     (in_rd),
    .rs1    (p0_rs1),
    .rs2    (in_rs2),
    .funct3 (p0_funct3),
    .funct7 (in_funct7),
    .imm    (p0_imm),
    .word   (p0_word),
    .err    (p0_err)
  );

  // Second li word: ADDI rd,rd,lo12
  inst_pack u_pack_addi (
    .fmt    (FMT_I),
    .opcode (ArithmeticI),
    .rd     (in_rd),
    .rs1    (in_rd),
    .rs2    (5'd0),
    .funct3 (3'd0),
    .funct7 (7'd0),
    .imm    ({{20{in_imm[11]}}, in_imm[11:0]}),
    .word   (p1_word),
    .err    (p1_err)
  );

  logic accept;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    pend_inst_d = pend_inst_q;
    pend_err_d  = pend_err_q;
    if (state_q == S_SECOND) begin
      if (out_ready) begin
        out_valid_d = 1'b1;
        out_inst_d  = pend_inst_q;
        out_last_d  = 1'b1;
        out_err_d   = pend_err_q;
        state_d     = S_IDLE;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = p0_word;
      out_err_d   = p0_err;
      out_last_d  = !li_two;
      pend_inst_d = p1_word;
      pend_err_d  = p1_err;
      state_d     = li_two ? S_SECOND : S_IDLE;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      pend_inst_q <= 32'd0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      pend_inst_q <= pend_inst_d;
      pend_err_q  <= pend_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: arithmetic reference model + per-cycle compare, plus literal vectors.
// Latency: expects each accepted request's first beat one cycle later.
// Backpressure: exercises output stalls, li second beat and reset mid-expansion.
module tb_inst_encoder;

  logic        clk, rstn;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_last, out_err;

  inst_encoder dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_last(out_last), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed range test done with integer arithmetic.
  function automatic bit sfit(input logic [31:0] v, input int n);
    longint s, lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic void push(input logic [31:0] w, input logic last, input logic err);
    beat_t b;
    b.inst = w; b.last = last; b.err = err;
    exp_q.push_back(b);
  endfunction

  // Reference: what beats a request must produce.
  function automatic void model(input req_t r);
    logic [31:0] x, w, hi32;
    int          lo;
    bit          bad;
    x = r.imm; bad = 0; w = 32'h0;
    case (r.fmt)
      3'd0: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      3'd1: begin
        if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          bad = (x > 32'd31);
          w = {r.f7, x[4:0], r.rs1, r.f3, r.rd, r.op};
        end else begin
          bad = !sfit(x, 12);
          w = {x[11:0], r.rs1, r.f3, r.rd, r.op};
        end
      end
      3'd2: begin bad = !sfit(x, 12); w = {x[11:5], r.rs2, r.rs1, r.f3, x[4:0], r.op}; end
      3'd3: begin
        bad = !sfit(x, 13) || (x % 2 != 0);
        w = {x[12], x[10:5], r.rs2, r.rs1, r.f3, x[4:1], x[11], r.op};
      end
      3'd4: begin bad = (x % 4096 != 0); w = {x[31:12], r.rd, r.op}; end
      3'd5: begin
        bad = !sfit(x, 21) || (x % 2 != 0);
        w = {x[20], x[10:1], x[11], x[19:12], r.rd, r.op};
      end
      3'd6: begin
        if (sfit(x, 12)) begin
          w = {x[11:0], 5'd0, 3'd0, r.rd, 7'h13};
        end else begin
          lo   = (int'(x[11:0]) >= 2048) ? int'(x[11:0]) - 4096 : int'(x[11:0]);
          hi32 = x - lo;
          if (lo == 0) begin
            w = {hi32[31:12], r.rd, 7'h37};
          end else begin
            push({hi32[31:12], r.rd, 7'h37}, 1'b0, 1'b0);
            w = {x[11:0], r.rd, 3'd0, r.rd, 7'h13};
          end
        end
      end
      default: bad = 1;
    endcase
    if (bad) push(32'h00000013, 1'b1, 1'b1);
    else     push(w, 1'b1, 1'b0);
  endfunction

  // Compare process: consumed beats vs model, stability while stalled.
  logic        hold_vld = 1'b0;
  logic [31:0] hold_inst;
  logic        hold_last, hold_err;
  always @(negedge clk) begin
    beat_t b;
    req_t  r;
    if (!rstn) begin
      exp_q.delete();
      hold_vld = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    end else begin
      if (hold_vld && out_valid) begin
        chk("hold_inst", out_inst, hold_inst);
        chk("hold_last", {31'd0, out_last}, {31'd0, hold_last});
        chk("hold_err", {31'd0, out_err}, {31'd0, hold_err});
      end else if (hold_vld) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", out_inst, 32'hxxxxxxxx);
        end else begin
          b = exp_q.pop_front();
          chk("model_inst", out_inst, b.inst);
          chk("model_last", {31'd0, out_last}, {31'd0, b.last});
          chk("model_err", {31'd0, out_err}, {31'd0, b.err});
        end
      end
      hold_vld  = out_valid && !out_ready;
      hold_inst = out_inst; hold_last = out_last; hold_err = out_err;
      if (in_valid && in_ready) begin
        r.fmt = in_fmt; r.op = in_opcode; r.rd = in_rd; r.rs1 = in_rs1; r.rs2 = in_rs2;
        r.f3 = in_funct3; r.f7 = in_funct7; r.imm = in_imm;
        model(r);
      end
    end
  end

  task automatic drive(input req_t r);
    in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
    in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  task automatic send(input req_t r);
    int n;
    @(posedge clk); #1;
    drive(r);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_beat(input logic [31:0] inst, input logic last, input logic err,
                           input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 20);
    if (!(out_valid && out_ready)) begin
      chk({name, "_timeout"}, {31'd0, out_valid}, 32'd1);
    end else begin
      chk(name, out_inst, inst);
      chk({name, "_last"}, {31'd0, out_last}, {31'd0, last});
      chk({name, "_err"}, {31'd0, out_err}, {31'd0, err});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    rstn = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    #1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_inst", out_inst, 32'd0);
    chk("reset_last", {31'd0, out_last}, 32'd0);
    chk("reset_err", {31'd0, out_err}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    idle(2);
    @(posedge clk); #2 rstn = 1'b1;

    // li needing LUI+ADDI
    send(mk(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF));
    wait_beat(32'h123462B7, 1'b0, 1'b0, "li2_lui");
    chk("li2_in_ready_between", {31'd0, in_ready}, 32'd0);
    wait_beat(32'hFFF28293, 1'b1, 1'b0, "li2_addi");

    send(mk(3'd6, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100));
    wait_beat(32'h06400093, 1'b1, 1'b0, "li_small");
    send(mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
    wait_beat(32'h001000EF, 1'b1, 1'b0, "jal_2048");

    send(mk(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4));
    wait_beat(32'hFE208EE3, 1'b1, 1'b0, "beq_m4");
    send(mk(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3));
    wait_beat(NOP, 1'b1, 1'b1, "beq_odd");
    send(mk(3'd2, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, -32'sd8));
    wait_beat(32'hFE21AC23, 1'b1, 1'b0, "sw_m8");

    send(mk(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd31));
    wait_beat(32'h41F15093, 1'b1, 1'b0, "srai_31");
    send(mk(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd32));
    wait_beat(NOP, 1'b1, 1'b1, "srai_32");

    // Model-only vectors: boundaries and error cases
    send(mk(3'd6, 7'd0, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000));
    send(mk(3'd6, 7'd0, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF));
    send(mk(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h80000FFF));
    send(mk(3'd6, 7'd0, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800));
    send(mk(3'd4, 7'b0110111, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123));
    send(mk(3'd4, 7'b0010111, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000));
    send(mk(3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0));
    send(mk(3'd1, 7'b0000011, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd2048));
    send(mk(3'd1, 7'b0000011, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd2048));
    send(mk(3'd0, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'b0100000, 32'd0));
    send(mk(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd4096));
    send(mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000));
    send(mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000));
    idle(4);

    // Back-to-back single-beat requests
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(mk(3'd1, 7'b0010011, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 32'(i * 100 - 200)));
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    idle(3);

    // Output stall during li expansion
    out_ready = 1'b0;
    send(mk(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_inst", out_inst, 32'h123462B7);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_beat(32'h123462B7, 1'b0, 1'b0, "stall_lui");
    wait_beat(32'hFFF28293, 1'b1, 1'b0, "stall_addi");
    idle(2);

    // Reset while the ADDI beat is pending
    out_ready = 1'b0;
    send(mk(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF));
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_inst", out_inst, 32'd0);
    chk("async_rst_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    idle(2);
    @(posedge clk); #2 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_addi_after_rst", {31'd0, out_valid}, 32'd0);
    end

    idle(3);
    chk("model_queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the immediate decoder: builds 32-bit RV32I instruction words from opcode, register fields and a full 32-bit immediate. Encodes the scattered immediates of the I/S/B/U/J formats, checks each immediate for range and alignment, and expands the `li` pseudo-op into LUI+ADDI when one instruction cannot hold the constant. Sits between the debug/boot instruction injector and the fetch-side injection port, with valid/ready on both sides and a registered output.

Parameters:
NOP_WORD, 32'h00000013, instruction word emitted on an encode error (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&&in_ready
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
in_opcode  input  7  opcode[6:0]; ignored for LI
in_rd  input  5  rd
in_rs1  input  5  rs1
in_rs2  input  5  rs2
in_funct3  input  3  funct3
in_funct7  input  7  funct7; also the upper bits of I-format shifts
in_imm  input  32  full signed immediate or byte offset
out_valid  output  1  beat valid
out_ready  input  1  beat consumed when out_valid&&out_ready
out_inst  output  32  encoded instruction
out_last  output  1  final beat of the request
out_err  output  1  request rejected; out_inst=NOP_WORD

Behaviour:
- Reset is asynchronous and active-low on rstn, clocked by clk. On reset: out_valid=0, out_inst=0, out_last=0, out_err=0, state=S_IDLE, and any pending beat is discarded. Assertion mid-LI drops the second beat.
- FSM has two states:
  - S_IDLE: output register holds no beat or a last beat.
  - S_SECOND: output holds the LUI beat; the ADDI beat waits in the pending register.
- in_ready = (state==S_IDLE) && (!out_valid || out_ready).
- Latency: request accepted at edge N is presented at N+1. Single-beat throughput is 1 request per cycle.
- While out_valid && !out_ready, all out_* hold stable.
- In S_SECOND with out_ready=1: the pending beat loads into the output with out_last=1, and the FSM returns to S_IDLE. A new request cannot be accepted that cycle.
- Encoding per format (imm = in_imm):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - I shift (opcode 0010011, funct3 001/101): {funct7,imm[4:0],rs1,funct3,rd,opcode}. Requires imm[31:5]==0.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}. Requires imm[11:0]==0.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Range checks:
  - I and S: imm must sign-fit 12 bits.
  - B: imm must sign-fit 13 bits and imm[0]==0.
  - J: imm must sign-fit 21 bits and imm[0]==0.
  - fmt 7: always an error.
- On a failed check: one beat, out_err=1, out_last=1, out_inst=NOP_WORD.
- LI expansion:
  - imm sign-fits 12 bits: one beat, ADDI rd,x0,imm.
  - Otherwise, if imm[11:0]==0: one beat, LUI rd,imm[31:12].
  - Otherwise two beats. First LUI rd,hi with hi=(imm+32'h800)[31:12], taken modulo 2^32, out_last=0. Then ADDI rd,rd,imm[11:0] with out_last=1.
  - LI with rd=x0 encodes normally; it is not an error.
- out_err is 0 on every successful beat.

Decomposition:
- Shared package rv_isa_pkg holds:
  - the opcode localparams (ArithmeticR/I, Conditionjump, MemoryLoad/Store, JumpandlinkR/I, Adduppertopc, Loadupperimm);
  - the FMT_* codes;
  - NOP_WORD.
- One combinational sub-module, inst_pack. It maps fields to {word, err} per format, with a range-check function per width. It is instantiated twice: once for the primary word and once for the LI ADDI word.
- The FSM and the output and pending registers stay in inst_encoder.

Test Plan:
- fmt=LI, rd=5, imm=32'h12345FFF, out_ready=1 -> beat1 32'h123462B7 with last=0; beat2 32'hFFF28293 with last=1; in_ready=0 in between.
- fmt=LI, rd=1, imm=100 -> single beat 32'h06400093, last=1. Then fmt=J, opcode 1101111, rd=1, imm=2048 -> 32'h001000EF.
- fmt=B, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3. Same request with imm=3 -> out_err=1, out_inst=32'h00000013.
- fmt=S, opcode 0100011, rs1=3, rs2=2, funct3=010, imm=-8 -> 32'hFE21AC23. Back-to-back I requests with out_ready=1 -> one beat per cycle.
- LI two-beat request with out_ready=0 for 3 cycles -> LUI beat held stable, in_ready=0. Deassert rstn during S_SECOND -> out_valid=0 asynchronously, no ADDI beat after release.
- fmt=I shift, funct3=101, funct7=0100000, imm=31 -> srai encoding with bits[31:25]=0100000. imm=32 -> out_err=1.
